// File: rtl/branch_update_queue.sv
// In-order queue of resolved branch results feeding the SAp predictor update ports.
// At most DEQ_WIDTH results issue per cycle; results issued together never share a PHT index.
module branch_update_queue #(
    parameter int ENQ_WIDTH           = 2,
    parameter int DEQ_WIDTH           = 2,
    parameter int DEPTH               = 8,
    parameter int ADDR_WIDTH          = 32,
    parameter int INSN_ADDR_BIT_WIDTH = 2,
    parameter int IDX_BITS            = 9,
    parameter int HIST_BITS           = 9,
    parameter int CTR_WIDTH           = 2
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [ENQ_WIDTH-1:0]             enqValid,
    input  logic [ENQ_WIDTH*ADDR_WIDTH-1:0]  enqAddr,
    input  logic [ENQ_WIDTH-1:0]             enqTaken,
    input  logic [ENQ_WIDTH-1:0]             enqMispred,
    input  logic [ENQ_WIDTH-1:0]             enqIsCondBr,
    input  logic [ENQ_WIDTH*HIST_BITS-1:0]   enqPrevHist,
    input  logic [ENQ_WIDTH*CTR_WIDTH-1:0]   enqPrevCtr,
    output logic                             enqReady,
    input  logic                             hold,
    output logic [DEQ_WIDTH-1:0]             updValid,
    output logic [DEQ_WIDTH*ADDR_WIDTH-1:0]  updAddr,
    output logic [DEQ_WIDTH-1:0]             updTaken,
    output logic [DEQ_WIDTH-1:0]             updMispred,
    output logic [DEQ_WIDTH-1:0]             updIsCondBr,
    output logic [DEQ_WIDTH*HIST_BITS-1:0]   updPrevHist,
    output logic [DEQ_WIDTH*CTR_WIDTH-1:0]   updPrevCtr,
    output logic [$clog2(DEPTH):0]           occupancy,
    output logic                             overflow
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int IDX_HI = IDX_BITS - 1 + INSN_ADDR_BIT_WIDTH;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic                  taken;
        logic                  mispred;
        logic                  is_cond;
        logic [HIST_BITS-1:0]  hist;
        logic [CTR_WIDTH-1:0]  ctr;
    } entry_t;

    entry_t             mem_q [DEPTH];
    entry_t             upd_q [DEQ_WIDTH];
    logic [DEQ_WIDTH-1:0] upd_valid_q;
    logic [PTR_W-1:0]   head_q, tail_q;
    logic [CNT_W-1:0]   count_q;
    logic               overflow_q;

    entry_t             enq_ent  [ENQ_WIDTH];
    logic [PTR_W-1:0]   enq_slot [ENQ_WIDTH];
    logic [ENQ_WIDTH-1:0] enq_fire;
    logic [CNT_W-1:0]   enq_cnt, n_enq;

    entry_t             rd_ent  [DEQ_WIDTH];
    logic [DEQ_WIDTH-1:0] iss;
    logic [CNT_W-1:0]   n_deq;
    logic               blocked, conflict;

    // Ready looks only at the registered count; a same-cycle dequeue earns no credit.
    assign enqReady  = (CNT_W'(DEPTH) - count_q) >= CNT_W'(ENQ_WIDTH);
    assign occupancy = count_q;
    assign overflow  = overflow_q;
    assign updValid  = upd_valid_q;

    // Compact valid lanes in lane order onto consecutive slots starting at tail.
    always_comb begin
        enq_cnt = '0;
        for (int l = 0; l < ENQ_WIDTH; l++) begin
            enq_slot[l]        = tail_q + enq_cnt[PTR_W-1:0];
            enq_ent[l].addr    = enqAddr[l*ADDR_WIDTH +: ADDR_WIDTH];
            enq_ent[l].taken   = enqTaken[l];
            enq_ent[l].mispred = enqMispred[l];
            enq_ent[l].is_cond = enqIsCondBr[l];
            enq_ent[l].hist    = enqPrevHist[l*HIST_BITS +: HIST_BITS];
            enq_ent[l].ctr     = enqPrevCtr[l*CTR_WIDTH +: CTR_WIDTH];
            if (enqValid[l]) begin
                enq_cnt = enq_cnt + CNT_W'(1);
            end
        end
        enq_fire = enqReady ? enqValid : '0;
        n_enq    = enqReady ? enq_cnt : '0;
    end

    // Issue walks candidates from head and stops at the first one that is absent or index-conflicting.
    always_comb begin
        iss     = '0;
        n_deq   = '0;
        blocked = hold;
        for (int k = 0; k < DEQ_WIDTH; k++) begin
            rd_ent[k] = mem_q[head_q + PTR_W'(k)];
            conflict  = 1'b0;
            for (int j = 0; j < k; j++) begin
                if (rd_ent[j].addr[IDX_HI:INSN_ADDR_BIT_WIDTH] ==
                    rd_ent[k].addr[IDX_HI:INSN_ADDR_BIT_WIDTH]) begin
                    conflict = 1'b1;
                end
            end
            if (blocked || CNT_W'(k) >= count_q || conflict) begin
                blocked = 1'b1;
            end else begin
                iss[k] = 1'b1;
                n_deq  = n_deq + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            upd_valid_q <= '0;
            for (int k = 0; k < DEQ_WIDTH; k++) begin
                upd_q[k] <= '0;
            end
        end else begin
            head_q      <= head_q + n_deq[PTR_W-1:0];
            tail_q      <= tail_q + n_enq[PTR_W-1:0];
            count_q     <= count_q + n_enq - n_deq;
            upd_valid_q <= iss;
            if (!enqReady && (|enqValid)) begin
                overflow_q <= 1'b1;
            end
            for (int k = 0; k < DEQ_WIDTH; k++) begin
                if (iss[k]) begin
                    upd_q[k] <= rd_ent[k];
                end
            end
        end
    end

    // Storage needs no reset: entries outside head..tail are never read.
    always_ff @(posedge clk) begin
        for (int l = 0; l < ENQ_WIDTH; l++) begin
            if (enq_fire[l]) begin
                mem_q[enq_slot[l]] <= enq_ent[l];
            end
        end
    end

    always_comb begin
        for (int k = 0; k < DEQ_WIDTH; k++) begin
            updAddr[k*ADDR_WIDTH +: ADDR_WIDTH]   = upd_q[k].addr;
            updTaken[k]                           = upd_q[k].taken;
            updMispred[k]                         = upd_q[k].mispred;
            updIsCondBr[k]                        = upd_q[k].is_cond;
            updPrevHist[k*HIST_BITS +: HIST_BITS] = upd_q[k].hist;
            updPrevCtr[k*CTR_WIDTH +: CTR_WIDTH]  = upd_q[k].ctr;
        end
    end

endmodule

// File: tb/tb_branch_update_queue.sv
// Bench for branch_update_queue: vector table, directed corner sequences and
// randomized traffic checked against a queue-based reference model.
module tb_branch_update_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  enqValid, enqTaken, enqMispred, enqIsCondBr;
    logic [63:0] enqAddr;
    logic [17:0] enqPrevHist;
    logic [3:0]  enqPrevCtr;
    logic        enqReady, hold, overflow;
    logic [1:0]  updValid, updTaken, updMispred, updIsCondBr;
    logic [63:0] updAddr;
    logic [17:0] updPrevHist;
    logic [3:0]  updPrevCtr;
    logic [3:0]  occupancy;

    branch_update_queue dut (
        .clk(clk), .rst_n(rst_n),
        .enqValid(enqValid), .enqAddr(enqAddr), .enqTaken(enqTaken),
        .enqMispred(enqMispred), .enqIsCondBr(enqIsCondBr),
        .enqPrevHist(enqPrevHist), .enqPrevCtr(enqPrevCtr), .enqReady(enqReady),
        .hold(hold), .updValid(updValid), .updAddr(updAddr), .updTaken(updTaken),
        .updMispred(updMispred), .updIsCondBr(updIsCondBr),
        .updPrevHist(updPrevHist), .updPrevCtr(updPrevCtr),
        .occupancy(occupancy), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        tk, mis, cond;
        logic [8:0]  hist;
        logic [1:0]  ctr;
    } ment_t;

    ment_t      q[$];
    ment_t      m_upd[2];
    logic [1:0] m_valid;
    logic       m_ovf;
    int         tests = 0;
    int         fails = 0;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endfunction

    function automatic int idx_of(logic [31:0] a);
        return int'((a / 4) % 512);
    endfunction

    task automatic model_reset();
        q.delete();
        m_valid = 2'b00;
        m_ovf   = 1'b0;
        for (int k = 0; k < 2; k++) m_upd[k] = '{default: '0};
    endtask

    // One clock edge of the reference: issue from the queue front, then accept new results.
    task automatic model_edge();
        bit ready;
        int n;
        ready   = (8 - q.size()) >= 2;
        m_valid = 2'b00;
        n       = 0;
        if (!hold) begin
            for (int k = 0; k < 2 && k < q.size(); k++) begin
                bit clash = 0;
                for (int j = 0; j < k; j++)
                    if (idx_of(q[j].addr) == idx_of(q[k].addr)) clash = 1;
                if (clash) break;
                m_valid[k] = 1'b1;
                m_upd[k]   = q[k];
                n++;
            end
        end
        repeat (n) void'(q.pop_front());
        if (ready) begin
            for (int l = 0; l < 2; l++) begin
                if (enqValid[l]) begin
                    ment_t e;
                    e.addr = enqAddr[l*32 +: 32];
                    e.tk   = enqTaken[l];
                    e.mis  = enqMispred[l];
                    e.cond = enqIsCondBr[l];
                    e.hist = enqPrevHist[l*9 +: 9];
                    e.ctr  = enqPrevCtr[l*2 +: 2];
                    q.push_back(e);
                end
            end
        end else if (|enqValid) begin
            m_ovf = 1'b1;
        end
    endtask

    task automatic compare_model();
        chk("updValid", updValid, m_valid);
        for (int k = 0; k < 2; k++) begin
            chk(k == 0 ? "lane0_fields" : "lane1_fields",
                {updAddr[k*32 +: 32], updTaken[k], updMispred[k], updIsCondBr[k],
                 updPrevHist[k*9 +: 9], updPrevCtr[k*2 +: 2]},
                {m_upd[k].addr, m_upd[k].tk, m_upd[k].mis, m_upd[k].cond,
                 m_upd[k].hist, m_upd[k].ctr});
        end
        chk("occupancy", occupancy, q.size());
        chk("overflow", overflow, m_ovf);
        chk("enqReady", enqReady, (8 - q.size()) >= 2);
    endtask

    task automatic step(input logic [1:0] v, input logic [31:0] a0, input logic [31:0] a1,
                        input logic [1:0] tk, input logic h);
        enqValid = v;
        enqAddr  = {a1, a0};
        enqTaken = tk;
        hold     = h;
        model_edge();
        @(posedge clk);
        #1;
        compare_model();
    endtask

    // Entered at 1 time unit after a rising edge; reset is asserted and released between edges.
    task automatic async_reset();
        #2;
        rst_n    = 1'b0;
        enqValid = 2'b00;
        hold     = 1'b0;
        #1;
        chk("rst_updValid", updValid, 2'b00);
        chk("rst_occupancy", occupancy, 0);
        chk("rst_enqReady", enqReady, 1'b1);
        chk("rst_overflow", overflow, 1'b0);
        chk("rst_updAddr", updAddr, 64'h0);
        model_reset();
        #1;
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [1:0]  v;
        logic [31:0] a0, a1;
        logic [1:0]  tk;
        logic [1:0]  ev;
        logic [31:0] ea0, ea1;
        logic [1:0]  etk;
        int          eocc;
    } vec_t;

    vec_t        tbl[9];
    logic [31:0] got[$];

    initial begin
        tbl[0] = '{2'b01, 32'h100, 32'h0,   2'b01, 2'b00, 32'h0,   32'h0,   2'b00, 1};
        tbl[1] = '{2'b00, 32'h0,   32'h0,   2'b00, 2'b01, 32'h100, 32'h0,   2'b01, 0};
        tbl[2] = '{2'b00, 32'h0,   32'h0,   2'b00, 2'b00, 32'h100, 32'h0,   2'b01, 0};
        tbl[3] = '{2'b11, 32'h100, 32'h104, 2'b10, 2'b00, 32'h100, 32'h0,   2'b01, 2};
        tbl[4] = '{2'b00, 32'h0,   32'h0,   2'b00, 2'b11, 32'h100, 32'h104, 2'b10, 0};
        tbl[5] = '{2'b11, 32'h100, 32'h900, 2'b00, 2'b00, 32'h100, 32'h104, 2'b10, 2};
        tbl[6] = '{2'b00, 32'h0,   32'h0,   2'b00, 2'b01, 32'h100, 32'h104, 2'b10, 1};
        tbl[7] = '{2'b00, 32'h0,   32'h0,   2'b00, 2'b01, 32'h900, 32'h104, 2'b10, 0};
        tbl[8] = '{2'b00, 32'h0,   32'h0,   2'b00, 2'b00, 32'h900, 32'h104, 2'b10, 0};

        rst_n = 1'b0; enqValid = '0; enqAddr = '0; enqTaken = '0; enqMispred = '0;
        enqIsCondBr = '0; enqPrevHist = '0; enqPrevCtr = '0; hold = 1'b0;
        model_reset();
        #3;
        chk("init_updValid", updValid, 2'b00);
        chk("init_occupancy", occupancy, 0);
        chk("init_enqReady", enqReady, 1'b1);
        chk("init_overflow", overflow, 1'b0);
        #4 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single result, distinct pair, index conflict.
        for (int i = 0; i < 9; i++) begin
            step(tbl[i].v, tbl[i].a0, tbl[i].a1, tbl[i].tk, 1'b0);
            chk("tbl_updValid", updValid, tbl[i].ev);
            chk("tbl_addr", updAddr, {tbl[i].ea1, tbl[i].ea0});
            chk("tbl_taken", updTaken, tbl[i].etk);
            chk("tbl_occupancy", occupancy, tbl[i].eocc);
        end

        // 20 back-to-back distinct-index results wrap the pointers several times.
        got.delete();
        for (int i = 0; i < 13; i++) begin
            if (i < 10) step(2'b11, 32'h1000 + 8*i, 32'h1004 + 8*i, 2'b00, 1'b0);
            else        step(2'b00, 32'h0, 32'h0, 2'b00, 1'b0);
            for (int k = 0; k < 2; k++)
                if (updValid[k]) got.push_back(updAddr[k*32 +: 32]);
        end
        chk("wrap_count", got.size(), 20);
        for (int i = 0; i < 20 && i < got.size(); i++)
            chk("wrap_order", got[i], 32'h1000 + 4*i);
        chk("wrap_overflow", overflow, 1'b0);

        // Fill under hold, drop a push when full, then drain in order.
        for (int i = 0; i < 4; i++)
            step(2'b11, 32'h200 + 8*i, 32'h204 + 8*i, 2'b00, 1'b1);
        chk("fill_occupancy", occupancy, 8);
        chk("fill_enqReady", enqReady, 1'b0);
        step(2'b11, 32'hA00, 32'hA04, 2'b00, 1'b1);
        chk("drop_overflow", overflow, 1'b1);
        chk("drop_occupancy", occupancy, 8);
        for (int i = 0; i < 4; i++) begin
            step(2'b00, 32'h0, 32'h0, 2'b00, 1'b0);
            chk("drain_valid", updValid, 2'b11);
            chk("drain_addr", updAddr, {32'h204 + 8*i, 32'h200 + 8*i});
            chk("drain_occupancy", occupancy, 6 - 2*i);
        end

        // Asynchronous reset at occupancy 5, then a single result again.
        step(2'b11, 32'h300, 32'h304, 2'b00, 1'b1);
        step(2'b11, 32'h308, 32'h30C, 2'b00, 1'b1);
        step(2'b01, 32'h310, 32'h0,   2'b00, 1'b1);
        chk("pre_rst_occupancy", occupancy, 5);
        async_reset();
        step(2'b01, 32'h100, 32'h0, 2'b01, 1'b0);
        chk("post_rst_valid0", updValid, 2'b00);
        step(2'b00, 32'h0, 32'h0, 2'b00, 1'b0);
        chk("post_rst_valid1", updValid, 2'b01);
        chk("post_rst_addr", updAddr[31:0], 32'h100);
        chk("post_rst_taken", updTaken[0], 1'b1);
        chk("post_rst_occupancy", occupancy, 0);

        // Random traffic: few index values to provoke conflicts, hold bursts to provoke drops.
        for (int c = 0; c < 600; c++) begin
            logic [31:0] ra0, ra1;
            if (c == 300) async_reset();
            ra0         = $urandom & 32'h0000_180C;
            ra1         = $urandom & 32'h0000_180C;
            enqMispred  = 2'($urandom);
            enqIsCondBr = 2'($urandom);
            enqPrevHist = 18'($urandom);
            enqPrevCtr  = 4'($urandom);
            step(2'($urandom), ra0, ra1, 2'($urandom), (c % 50) < 8);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/branch_update_queue.md
Name: branch_update_queue

Overview:
- Buffers resolved branch results from the integer execute stage before they reach the SAp predictor's update ports.
- Results are issued to the predictor in order, up to DEQ_WIDTH per cycle.
- Two results issued in the same cycle never share a PHT index, so the predictor never sees a same-bank multi-write.
- Sits between the branch-resolution logic and the predictor's brResult inputs.

Parameters:
ENQ_WIDTH, 2, result lanes from execute (matches INT_ISSUE_WIDTH)
DEQ_WIDTH, 2, update lanes to predictor
DEPTH, 8, queue entries; power of two, >= ENQ_WIDTH
ADDR_WIDTH, 32, branch address width
INSN_ADDR_BIT_WIDTH, 2, low address bits dropped for indexing
IDX_BITS, 9, PHT index width
HIST_BITS, 9, per-address history width
CTR_WIDTH, 2, saturating-counter width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
enqValid  in  ENQ_WIDTH  lane carries a resolved branch
enqAddr  in  ENQ_WIDTH*ADDR_WIDTH  branch PC per lane
enqTaken  in  ENQ_WIDTH  executed direction
enqMispred  in  ENQ_WIDTH  branch was mispredicted
enqIsCondBr  in  ENQ_WIDTH  conditional branch
enqPrevHist  in  ENQ_WIDTH*HIST_BITS  history used at prediction
enqPrevCtr  in  ENQ_WIDTH*CTR_WIDTH  counter value used at prediction
enqReady  out  1  at least ENQ_WIDTH free entries
hold  in  1  predictor in reset sequence; suppress issue
updValid  out  DEQ_WIDTH  update lane valid (registered)
updAddr, updTaken, updMispred, updIsCondBr, updPrevHist, updPrevCtr  out  DEQ_WIDTH x field width  registered copies of the issued entry fields
occupancy  out  $clog2(DEPTH)+1  current entry count
overflow  out  1  sticky: a valid result was dropped

Behaviour:
- **Storage:** circular buffer with head/tail pointers of $clog2(DEPTH) bits, wrapping modulo DEPTH. The count register drives occupancy.
- **Ready:** enqReady = (DEPTH - count) >= ENQ_WIDTH. It is combinational from the registered count only; same-cycle dequeue is not credited.
- **Enqueue:** when enqReady=1, valid lanes are compacted in lane order (lane 0 first) and written at tail at the clock edge. Invalid lanes consume no entry.
- **Drop:** when enqReady=0, every valid lane is dropped and overflow is set. overflow is cleared only by reset.
- **Index:** idx(e) = addr[IDX_BITS-1+INSN_ADDR_BIT_WIDTH : INSN_ADDR_BIT_WIDTH].
- **Issue selection** (each cycle, hold=0), over entries present at the start of the cycle:
  - Candidate k (k=0..min(count,DEQ_WIDTH)-1) is issued only if candidate k-1 was issued and idx(k) differs from idx of every earlier issued candidate.
  - Selection stops at the first blocked candidate, so order is strictly preserved.
  - The issued entries go to updValid/upd* lanes 0..n-1 at the edge; head advances by n.
- **Outputs:** updValid is 0 on any cycle with nothing issued. upd* data fields hold their last value when not valid.
- **Latency:** a result enqueued at edge E is eligible during cycle E+1 and appears on upd* after edge E+1. Minimum latency is 2 edges; there is no bypass.
- **Simultaneous enq/deq:** count_next = count + nEnq - nDeq; both pointers update in the same edge.
- **Hold:** no issue; updValid=0 after the next edge. Enqueue continues normally.
- **Reset (asynchronous, any time, mid-operation included):**
  - head=tail=count=0, updValid=0, all upd* fields 0, overflow=0.
  - enqReady=1 immediately.
  - Queued contents are discarded.
- **Never:** an issued lane beyond a blocked candidate; issue from an empty queue (count=0 means no issue).

Test Plan:
1. Single result: lane0 enqValid, addr 0x100, taken=1 at edge E. Required: updValid=2'b01, updAddr[0]=0x100, updTaken[0]=1 after edge E+1; occupancy returns to 0.
2. Pair, distinct index: addr 0x100 (lane0) and 0x104 (lane1). Required: both issued in the same cycle on lanes 0/1, in that order.
3. Index conflict: addr 0x100 and 0x900 (same idx). Required: 0x100 on lane0 with updValid=01; 0x900 on lane0 one cycle later.
4. Fill/overflow: hold=1, two results per cycle for 4 cycles, reaching occupancy=8 and enqReady=0. A 5th valid push is dropped, overflow=1, occupancy stays 8. Release hold: drains 2 per cycle over 4 cycles in enqueue order.
5. Wrap-around: 20 back-to-back distinct-index results, one per lane per cycle with hold=0. Required: all 20 emerge in order, none dropped, overflow=0.
6. Async reset mid-run at occupancy=5: drop rst_n between edges. Required: updValid=0, occupancy=0, enqReady=1, overflow=0 before the next edge; after reset, new traffic behaves as in scenario 1.
